// File: rtl/sb_tx_arbiter_if.sv
// sb_tx_arbiter_if: message type and requester/transmitter bundle for the sideband TX arbiter
package sb_tx_arbiter_pkg;
    typedef logic [63:0] SB_msg_t;
endpackage

interface sb_tx_arbiter_if #(parameter int N_REQ = 4);
    import sb_tx_arbiter_pkg::*;
    localparam int IW = $clog2(N_REQ);
    SB_msg_t req_msg_i [N_REQ];
    logic [N_REQ-1:0] req_valid_i;
    logic [N_REQ-1:0] req_ack_o;
    SB_msg_t TX_msg_o;
    logic TX_msg_valid_o;
    logic TX_msg_valid_ack_i;
    logic [IW-1:0] grant_idx_o;
    logic busy_o;
    logic timeout_o;
    modport master (
        input req_msg_i, req_valid_i, TX_msg_valid_ack_i,
        output req_ack_o, TX_msg_o, TX_msg_valid_o, grant_idx_o, busy_o, timeout_o
    );
    modport slave (
        output req_msg_i, req_valid_i, TX_msg_valid_ack_i,
        input req_ack_o, TX_msg_o, TX_msg_valid_o, grant_idx_o, busy_o, timeout_o
    );
endinterface

// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter: round-robin share of the sideband TX channel; SB_TX_ARB_TIMEOUT_EN adds a stalled-grant abort
module sb_tx_arbiter
    import sb_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TIMEOUT_CYCLES = 800000
) (
    input logic clk_100MHz,
    input logic reset,
    sb_tx_arbiter_if.master bus
);
    localparam int IW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] last_grant, winner, cand;
    logic found, grant, take_ack, abort;
    if (N_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("sb_tx_arbiter: N_REQ and TIMEOUT_CYCLES must be at least 2");
    end
    // Scan from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        winner = last_grant;
        found = 1'b0;
        cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_grant) + k) % N_REQ);
            if (bus.req_valid_i[cand]) begin
                winner = cand;
                found = 1'b1;
            end
        end
    end
`ifdef SB_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign abort = state == WAIT_ACK && !bus.TX_msg_valid_ack_i && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk_100MHz) begin
        cnt <= (reset || state != WAIT_ACK) ? '0 : cnt + CW'(1);
        bus.timeout_o <= reset ? 1'b0 : abort;
    end
`else
    assign abort = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif
    always_comb begin
        grant = state == IDLE && found;
        take_ack = state == WAIT_ACK && bus.TX_msg_valid_ack_i;
        state_n = grant ? WAIT_ACK : take_ack ? DONE : (state == DONE || abort) ? IDLE : state;
    end
    always_ff @(posedge clk_100MHz) begin
        state <= reset ? IDLE : state_n;
    end
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            last_grant <= IW'(N_REQ - 1);
            bus.TX_msg_o <= '0;
            bus.TX_msg_valid_o <= 1'b0;
            bus.grant_idx_o <= '0;
            bus.req_ack_o <= '0;
        end else begin
            if (grant) begin
                bus.TX_msg_o <= bus.req_msg_i[winner];
                bus.grant_idx_o <= winner;
            end
            bus.TX_msg_valid_o <= grant ? 1'b1 : (take_ack || abort) ? 1'b0 : bus.TX_msg_valid_o;
            if (take_ack || abort) last_grant <= bus.grant_idx_o;
            bus.req_ack_o <= take_ack ? (N_REQ'(1) << bus.grant_idx_o) : '0;
        end
    end
    assign bus.busy_o = state != IDLE;
endmodule

// File: tb/tb_sb_tx_arbiter.sv
// tb_sb_tx_arbiter: directed checks of grant order, handshake timing, reset abort and timeout
module tb_sb_tx_arbiter;
    import sb_tx_arbiter_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    sb_tx_arbiter_if #(.N_REQ(4)) bus ();
    sb_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk_100MHz(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;

    function automatic SB_msg_t msg_of(int i);
        return 64'hA5A5_0000_0000_0000 | (64'(i + 1) * 64'h0101_0101);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        bus.req_valid_i = '0;
        bus.TX_msg_valid_ack_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid_i = '0;
        bus.TX_msg_valid_ack_i = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if ({bus.TX_msg_o, bus.TX_msg_valid_o, bus.req_ack_o, bus.grant_idx_o, bus.busy_o, bus.timeout_o} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle c=%0d: msg=%h valid=%b ack=%b grant=%0d busy=%b timeout=%b, all required 0",
                         c, bus.TX_msg_o, bus.TX_msg_valid_o, bus.req_ack_o, bus.grant_idx_o, bus.busy_o, bus.timeout_o);
            end
        end
    endtask

    task automatic test_single();
        SB_msg_t x = 64'hDEAD_BEEF_0000_0002;
        bus.req_msg_i[2] = x;
        bus.req_valid_i = 4'b0100;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if ({bus.TX_msg_valid_o, bus.grant_idx_o, bus.req_ack_o, bus.busy_o} !== {1'b1, 2'd2, 4'b0000, 1'b1}
                || bus.TX_msg_o !== x) begin
                miscompares++;
                $display("FAIL single_hold c=%0d: valid=%b grant=%0d ack=%b busy=%b msg=%h, required 1/2/0000/1/%h",
                         c, bus.TX_msg_valid_o, bus.grant_idx_o, bus.req_ack_o, bus.busy_o, bus.TX_msg_o, x);
            end
        end
        bus.TX_msg_valid_ack_i = 1'b1;
        tick();
        vectors++;
        if ({bus.TX_msg_valid_o, bus.req_ack_o, bus.busy_o} !== {1'b0, 4'b0100, 1'b1}) begin
            miscompares++;
            $display("FAIL single_ack: valid=%b ack=%b busy=%b, required 0/0100/1",
                     bus.TX_msg_valid_o, bus.req_ack_o, bus.busy_o);
        end
        bus.TX_msg_valid_ack_i = 1'b0;
        bus.req_valid_i = '0;
        tick();
        vectors++;
        if ({bus.TX_msg_valid_o, bus.req_ack_o, bus.busy_o} !== {1'b0, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL single_done: valid=%b ack=%b busy=%b, required 0/0000/0",
                     bus.TX_msg_valid_o, bus.req_ack_o, bus.busy_o);
        end
        bus.req_msg_i[2] = msg_of(2);
        tick();
    endtask

    task automatic test_round_robin();
        reset_dut();
        bus.req_valid_i = 4'b1111;
        bus.TX_msg_valid_ack_i = 1'b1;
        for (int g = 0; g < 8; g++) begin
            logic [1:0] w;
            w = 2'(g % 4);
            tick();
            vectors++;
            if ({bus.TX_msg_valid_o, bus.grant_idx_o, bus.req_ack_o, bus.busy_o} !== {1'b1, w, 4'b0000, 1'b1}
                || bus.TX_msg_o !== msg_of(int'(w))) begin
                miscompares++;
                $display("FAIL rr_grant g=%0d: valid=%b grant=%0d ack=%b busy=%b msg=%h, required 1/%0d/0000/1/%h",
                         g, bus.TX_msg_valid_o, bus.grant_idx_o, bus.req_ack_o, bus.busy_o, bus.TX_msg_o, w, msg_of(int'(w)));
            end
            tick();
            vectors++;
            if ({bus.TX_msg_valid_o, bus.req_ack_o} !== {1'b0, 4'b0001 << w}) begin
                miscompares++;
                $display("FAIL rr_ack g=%0d: valid=%b ack=%b, required 0/%b", g, bus.TX_msg_valid_o, bus.req_ack_o, 4'b0001 << w);
            end
            tick();
            vectors++;
            if ({bus.busy_o, bus.req_ack_o} !== {1'b0, 4'b0000}) begin
                miscompares++;
                $display("FAIL rr_done g=%0d: busy=%b ack=%b, required 0/0000", g, bus.busy_o, bus.req_ack_o);
            end
        end
        bus.req_valid_i = '0;
    endtask

    task automatic test_ack_early();
        int vcnt = 0;
        int acnt = 0;
        bus.TX_msg_valid_ack_i = 1'b1;
        repeat (2) begin
            tick();
            vectors++;
            if ({bus.TX_msg_valid_o, bus.busy_o, bus.req_ack_o} !== {1'b0, 1'b0, 4'b0000}) begin
                miscompares++;
                $display("FAIL early_idle: valid=%b busy=%b ack=%b, required 0/0/0000", bus.TX_msg_valid_o, bus.busy_o, bus.req_ack_o);
            end
        end
        bus.req_valid_i = 4'b0010;
        tick();
        vectors++;
        if ({bus.TX_msg_valid_o, bus.grant_idx_o, bus.req_ack_o} !== {1'b1, 2'd1, 4'b0000}) begin
            miscompares++;
            $display("FAIL early_grant: valid=%b grant=%0d ack=%b, required 1/1/0000", bus.TX_msg_valid_o, bus.grant_idx_o, bus.req_ack_o);
        end
        vcnt = int'(bus.TX_msg_valid_o);
        for (int c = 0; c < 5; c++) begin
            tick();
            vcnt += int'(bus.TX_msg_valid_o);
            acnt += int'(bus.req_ack_o[1]);
            if (bus.req_ack_o[1]) bus.req_valid_i = '0;
            vectors++;
            if ((bus.req_ack_o & 4'b1101) !== 4'b0000) begin
                miscompares++;
                $display("FAIL early_onehot c=%0d: ack=%b, required only bit 1 or none", c, bus.req_ack_o);
            end
        end
        vectors++;
        if (vcnt !== 1 || acnt !== 1) begin
            miscompares++;
            $display("FAIL early_counts: valid cycles=%0d ack pulses=%0d, required 1/1", vcnt, acnt);
        end
        bus.TX_msg_valid_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.req_valid_i = 4'b1001;
        tick();
        vectors++;
        if ({bus.TX_msg_valid_o, bus.grant_idx_o} !== {1'b1, 2'd3}) begin
            miscompares++;
            $display("FAIL mid_grant: valid=%b grant=%0d, required 1/3", bus.TX_msg_valid_o, bus.grant_idx_o);
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({bus.TX_msg_o, bus.TX_msg_valid_o, bus.req_ack_o, bus.grant_idx_o, bus.busy_o, bus.timeout_o} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: msg=%h valid=%b ack=%b grant=%0d busy=%b timeout=%b, all required 0",
                     bus.TX_msg_o, bus.TX_msg_valid_o, bus.req_ack_o, bus.grant_idx_o, bus.busy_o, bus.timeout_o);
        end
        tick();
        vectors++;
        if ({bus.TX_msg_valid_o, bus.grant_idx_o, bus.req_ack_o} !== {1'b1, 2'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL mid_regrant: valid=%b grant=%0d ack=%b, required 1/0/0000", bus.TX_msg_valid_o, bus.grant_idx_o, bus.req_ack_o);
        end
        bus.TX_msg_valid_ack_i = 1'b1;
        tick();
        vectors++;
        if (bus.req_ack_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_ack: ack=%b, required 0001", bus.req_ack_o);
        end
        bus.TX_msg_valid_ack_i = 1'b0;
        bus.req_valid_i = '0;
        repeat (2) tick();
    endtask

    task automatic test_timeout();
        reset_dut();
        bus.req_valid_i = 4'b0101;
        tick();
        vectors++;
        if ({bus.TX_msg_valid_o, bus.grant_idx_o} !== {1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL to_grant: valid=%b grant=%0d, required 1/0", bus.TX_msg_valid_o, bus.grant_idx_o);
        end
`ifdef SB_TX_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            tick();
            vectors++;
            if (k < 16 && {bus.TX_msg_valid_o, bus.timeout_o, bus.busy_o} !== {1'b1, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL to_wait k=%0d: valid=%b timeout=%b busy=%b, required 1/0/1", k, bus.TX_msg_valid_o, bus.timeout_o, bus.busy_o);
            end
            if (k == 16 && {bus.TX_msg_valid_o, bus.timeout_o, bus.busy_o, bus.req_ack_o} !== {1'b0, 1'b1, 1'b0, 4'b0000}) begin
                miscompares++;
                $display("FAIL to_fire: valid=%b timeout=%b busy=%b ack=%b, required 0/1/0/0000",
                         bus.TX_msg_valid_o, bus.timeout_o, bus.busy_o, bus.req_ack_o);
            end
        end
        tick();
        vectors++;
        if ({bus.TX_msg_valid_o, bus.grant_idx_o, bus.timeout_o} !== {1'b1, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL to_next: valid=%b grant=%0d timeout=%b, required 1/2/0", bus.TX_msg_valid_o, bus.grant_idx_o, bus.timeout_o);
        end
        bus.TX_msg_valid_ack_i = 1'b1;
        tick();
        vectors++;
        if (bus.req_ack_o !== 4'b0100) begin
            miscompares++;
            $display("FAIL to_next_ack: ack=%b, required 0100", bus.req_ack_o);
        end
`else
        for (int k = 1; k <= 30; k++) begin
            tick();
            vectors++;
            if ({bus.TX_msg_valid_o, bus.grant_idx_o, bus.timeout_o} !== {1'b1, 2'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL hold_forever k=%0d: valid=%b grant=%0d timeout=%b, required 1/0/0",
                         k, bus.TX_msg_valid_o, bus.grant_idx_o, bus.timeout_o);
            end
        end
        bus.TX_msg_valid_ack_i = 1'b1;
        tick();
        vectors++;
        if (bus.req_ack_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL hold_ack: ack=%b, required 0001", bus.req_ack_o);
        end
`endif
        bus.TX_msg_valid_ack_i = 1'b0;
        bus.req_valid_i = '0;
        repeat (2) tick();
    endtask

    task automatic test_ack_on_terminal();
        reset_dut();
        bus.req_valid_i = 4'b0101;
        tick();
        vectors++;
        if ({bus.TX_msg_valid_o, bus.grant_idx_o} !== {1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL term_grant: valid=%b grant=%0d, required 1/0", bus.TX_msg_valid_o, bus.grant_idx_o);
        end
        for (int k = 1; k <= 15; k++) begin
            tick();
            vectors++;
            if ({bus.TX_msg_valid_o, bus.timeout_o} !== {1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL term_wait k=%0d: valid=%b timeout=%b, required 1/0", k, bus.TX_msg_valid_o, bus.timeout_o);
            end
        end
        bus.TX_msg_valid_ack_i = 1'b1;
        tick();
        vectors++;
        if ({bus.TX_msg_valid_o, bus.timeout_o, bus.req_ack_o} !== {1'b0, 1'b0, 4'b0001}) begin
            miscompares++;
            $display("FAIL term_ack_wins: valid=%b timeout=%b ack=%b, required 0/0/0001", bus.TX_msg_valid_o, bus.timeout_o, bus.req_ack_o);
        end
        bus.TX_msg_valid_ack_i = 1'b0;
        bus.req_valid_i = '0;
        tick();
        vectors++;
        if ({bus.timeout_o, bus.req_ack_o, bus.busy_o} !== {1'b0, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL term_after: timeout=%b ack=%b busy=%b, required 0/0000/0", bus.timeout_o, bus.req_ack_o, bus.busy_o);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bus.req_msg_i[i] = msg_of(i);
        bus.req_valid_i = '0;
        bus.TX_msg_valid_ack_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_ack_early();
        test_reset_mid();
        test_timeout();
        test_ack_on_terminal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end
endmodule
